// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO bank.
// Holds the register map offsets, interrupt mode encodings, the address
// decode range and a byte-select expansion helper used by the register file.
package wb_gpio_pkg;

  localparam int WB_DECODE_MSB = 31;
  localparam int WB_DECODE_LSB = 8;

  localparam logic [7:0] OFS_OUT      = 8'h00;
  localparam logic [7:0] OFS_OUT_SET  = 8'h04;
  localparam logic [7:0] OFS_OUT_CLR  = 8'h08;
  localparam logic [7:0] OFS_OUT_TGL  = 8'h0C;
  localparam logic [7:0] OFS_OE       = 8'h10;
  localparam logic [7:0] OFS_IN       = 8'h14;
  localparam logic [7:0] OFS_IRQ_EN   = 8'h18;
  localparam logic [7:0] OFS_IRQ_MODE = 8'h1C;
  localparam logic [7:0] OFS_IRQ_POL  = 8'h20;
  localparam logic [7:0] OFS_IRQ_STAT = 8'h24;
  localparam logic [7:0] OFS_FILT     = 8'h28;

  localparam logic IRQ_MODE_EDGE  = 1'b0;
  localparam logic IRQ_MODE_LEVEL = 1'b1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Expand the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_bank_in_filter.sv
// Per-pin input conditioning: a SYNC_STAGES-deep synchroniser followed by a
// glitch filter. The filtered value f only follows the synchronised value s
// once s has differed from f for filt+1 consecutive cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   pin         - raw asynchronous pad input
//   filt        - filter threshold (cycles a change must persist beyond)
//   f           - filtered input
//   f_prev      - f delayed by one cycle, for edge detection
module gpio_in_filter
  import wb_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pin,
  input  logic [FILT_W-1:0] filt,
  output logic              f,
  output logic              f_prev
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [FILT_W-1:0]      cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      f      <= 1'b0;
      f_prev <= 1'b0;
    end else begin
      // synchroniser stages
      sync   <= {sync[SYNC_STAGES-2:0], pin};
      // filter stage; the equality test means a counter already past a
      // freshly lowered threshold must wrap around before it can match
      f_prev <= f;
      if (s == f) begin
        cnt <= '0;
      end else if (cnt == filt) begin
        f   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank of NUM_IO pins.
// Provides per-pin direction, atomic set/clear/toggle of outputs, filtered
// inputs and per-pin edge/level interrupts combined onto irq_o.
// Ports:
//   wb_clk_i, wb_rst_ni          - clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i   - Wishbone request
//   wbs_adr_i, wbs_dat_i         - byte address, write data
//   wbs_dat_o, wbs_ack_o         - read data (valid only with ack), ack
//   io_in, io_out, io_oeb        - pad input, output, active-low enable
//   irq_o                        - aggregated interrupt
module wb_gpio_bank
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_IO      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_W      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq_o
);

  bus_state_e        state;
  logic              hit;
  logic              wr;
  logic [7:0]        ofs;
  logic [31:0]       byte_mask;
  logic [NUM_IO-1:0] wmask;
  logic [NUM_IO-1:0] wdata;
  logic [NUM_IO-1:0] w1;
  logic [FILT_W-1:0] fmask;
  logic [31:0]       rdata;
  logic              unused_adr;

  logic [NUM_IO-1:0] out_reg;
  logic [NUM_IO-1:0] oe_reg;
  logic [NUM_IO-1:0] irq_en;
  logic [NUM_IO-1:0] irq_mode;
  logic [NUM_IO-1:0] irq_pol;
  logic [NUM_IO-1:0] irq_stat;
  logic [FILT_W-1:0] filt_reg;
  logic [NUM_IO-1:0] stat_clr;

  logic [NUM_IO-1:0] f_vec;
  logic [NUM_IO-1:0] f_prev_vec;
  logic [NUM_IO-1:0] irq_cond;

  // Byte-select masked merge for read/write registers.
  function automatic logic [NUM_IO-1:0] merge(input logic [NUM_IO-1:0] old_v,
                                              input logic [NUM_IO-1:0] new_v,
                                              input logic [NUM_IO-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign hit = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[WB_DECODE_MSB:WB_DECODE_LSB] ==
                BASE_ADDR[WB_DECODE_MSB:WB_DECODE_LSB]);

  // Word-aligned offset; the byte lane bits are carried by wbs_sel_i.
  assign ofs        = {wbs_adr_i[7:2], 2'b00};
  assign unused_adr = ^wbs_adr_i[1:0];

  // A request is taken only from IDLE, so the write lands on the same edge
  // that raises ack and the following cycle is always ack-free.
  assign wr        = hit & wbs_we_i & (state == BUS_IDLE);
  assign byte_mask = sel_to_mask(wbs_sel_i);
  assign wmask     = byte_mask[NUM_IO-1:0];
  assign wdata     = wbs_dat_i[NUM_IO-1:0];
  assign w1        = wdata & wmask;
  assign fmask     = byte_mask[FILT_W-1:0];
  assign stat_clr  = (wr && ofs == OFS_IRQ_STAT) ? w1 : '0;

  assign io_oeb = ~oe_reg;

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_OUT:      rdata[NUM_IO-1:0] = out_reg;
      OFS_OE:       rdata[NUM_IO-1:0] = oe_reg;
      OFS_IN:       rdata[NUM_IO-1:0] = f_vec;
      OFS_IRQ_EN:   rdata[NUM_IO-1:0] = irq_en;
      OFS_IRQ_MODE: rdata[NUM_IO-1:0] = irq_mode;
      OFS_IRQ_POL:  rdata[NUM_IO-1:0] = irq_pol;
      OFS_IRQ_STAT: rdata[NUM_IO-1:0] = irq_stat;
      OFS_FILT:     rdata[FILT_W-1:0] = filt_reg;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    irq_cond = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (irq_mode[i] == IRQ_MODE_LEVEL) begin
        irq_cond[i] = (f_vec[i] == ~irq_pol[i]);
      end else begin
        irq_cond[i] = irq_pol[i] ? (~f_vec[i] & f_prev_vec[i])
                                 : (f_vec[i] & ~f_prev_vec[i]);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= BUS_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (hit) begin
            state     <= BUS_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? '0 : rdata;
          end
        end
        BUS_ACK: begin
          state     <= BUS_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
        default: begin
          state     <= BUS_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_reg  <= '0;
      oe_reg   <= '0;
      irq_en   <= '0;
      irq_mode <= '0;
      irq_pol  <= '0;
      irq_stat <= '0;
      filt_reg <= '0;
      io_out   <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (wr) begin
        case (ofs)
          OFS_OUT:      out_reg  <= merge(out_reg, wdata, wmask);
          OFS_OUT_SET:  out_reg  <= out_reg | w1;
          OFS_OUT_CLR:  out_reg  <= out_reg & ~w1;
          OFS_OUT_TGL:  out_reg  <= out_reg ^ w1;
          OFS_OE:       oe_reg   <= merge(oe_reg, wdata, wmask);
          OFS_IRQ_EN:   irq_en   <= merge(irq_en, wdata, wmask);
          OFS_IRQ_MODE: irq_mode <= merge(irq_mode, wdata, wmask);
          OFS_IRQ_POL:  irq_pol  <= merge(irq_pol, wdata, wmask);
          OFS_FILT:     filt_reg <= (filt_reg & ~fmask) | (wbs_dat_i[FILT_W-1:0] & fmask);
          default: ;
        endcase
      end
      // A new event in the same cycle as a W1C wins over the clear.
      irq_stat <= (irq_stat & ~stat_clr) | irq_cond;
      // output stage
      io_out   <= out_reg;
      irq_o    <= |(irq_stat & irq_en);
    end
  end

  for (genvar g = 0; g < NUM_IO; g++) begin : g_pin
    gpio_in_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W)
    ) u_filt (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .pin   (io_in[g]),
      .filt  (filt_reg),
      .f     (f_vec[g]),
      .f_prev(f_prev_vec[g])
    );
  end

endmodule

// File: tb/tb_wb_gpio_bank.sv
module tb_wb_gpio_bank;
  import wb_gpio_pkg::*;

  localparam int          NUM_IO = 32;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cyc, stb, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat_w, dat_r;
  logic              ack;
  logic [NUM_IO-1:0] io_in, io_out, io_oeb;
  logic              irq;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb[$];

  wb_gpio_bank #(
    .NUM_IO(NUM_IO), .BASE_ADDR(BASE), .SYNC_STAGES(2), .FILT_W(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_dat_o(dat_r),
    .wbs_ack_o(ack),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One classic Wishbone access; ack must appear exactly one edge after stb.
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input string tag);
    sb_t e;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    @(posedge clk); #1;
    check({tag, " ack"}, {31'b0, ack}, 32'd1);
    if (!w && sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, dat_r, e.exp);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_w = '0;
    @(posedge clk); #1;
    check({tag, " ack gap"}, {31'b0, ack}, 32'd0);
    check({tag, " dat idle"}, dat_r, 32'd0);
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d, input string tag);
    bus(1'b1, BASE + {24'h0, ofs}, 4'hF, d, tag);
  endtask

  task automatic rd(input logic [7:0] ofs, input logic [31:0] exp, input string tag);
    sb.push_back('{exp: exp, tag: tag});
    bus(1'b0, BASE + {24'h0, ofs}, 4'hF, 32'h0, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
    io_in = '0;
    cycles(3);
    check("rst io_oeb", io_oeb, 32'hFFFF_FFFF);
    check("rst io_out", io_out, 32'h0);
    check("rst irq", {31'b0, irq}, 32'd0);
    check("rst ack", {31'b0, ack}, 32'd0);
    check("rst dat", dat_r, 32'h0);
    rst_n = 1'b1;
    cycles(2);
    rd(OFS_OUT, 32'h0, "rst OUT");
    rd(OFS_OE, 32'h0, "rst OE");
    rd(OFS_IRQ_STAT, 32'h0, "rst STAT");

    // outputs and atomic updates
    wr(OFS_OE, 32'h0000_00FF, "wr OE");
    check("io_oeb", io_oeb, 32'hFFFF_FF00);
    wr(OFS_OUT, 32'h0000_00F0, "wr OUT");
    check("io_out OUT", io_out, 32'h0000_00F0);
    wr(OFS_OUT_SET, 32'h0F, "wr SET");
    check("io_out SET", io_out, 32'h0000_00FF);
    wr(OFS_OUT_CLR, 32'h81, "wr CLR");
    check("io_out CLR", io_out, 32'h0000_007E);
    wr(OFS_OUT_TGL, 32'hFF, "wr TGL");
    check("io_out TGL", io_out, 32'h0000_0081);
    rd(OFS_OUT, 32'h0000_0081, "rd OUT");
    rd(OFS_OUT_SET, 32'h0, "rd SET");
    rd(OFS_OE, 32'h0000_00FF, "rd OE");

    // glitch filter: FILT=4 -> 2+4+1 = 7 cycle latency
    wr(OFS_FILT, 32'h4, "wr FILT4");
    rd(OFS_FILT, 32'h4, "rd FILT");
    io_in[0] = 1'b1;
    cycles(3);
    io_in[0] = 1'b0;
    cycles(12);
    rd(OFS_IN, 32'h0, "IN pulse rejected");
    io_in[0] = 1'b1;
    cycles(6);
    rd(OFS_IN, 32'h0, "IN before latency");
    io_in[0] = 1'b0;
    cycles(12);
    rd(OFS_IN, 32'h0, "IN low again");
    io_in[0] = 1'b1;
    cycles(7);
    rd(OFS_IN, 32'h1, "IN at latency");

    // edge interrupt
    wr(OFS_FILT, 32'h0, "wr FILT0");
    wr(OFS_IRQ_STAT, 32'hFFFF_FFFF, "clr STAT");
    rd(OFS_IRQ_STAT, 32'h0, "STAT clear");
    wr(OFS_IRQ_EN, 32'h8, "wr EN");
    io_in[3] = 1'b1;
    cycles(8);
    rd(OFS_IRQ_STAT, 32'h8, "STAT rise");
    check("irq rise", {31'b0, irq}, 32'd1);
    wr(OFS_IRQ_STAT, 32'h8, "w1c STAT");
    check("irq cleared", {31'b0, irq}, 32'd0);
    rd(OFS_IRQ_STAT, 32'h0, "STAT after w1c");
    io_in[3] = 1'b0;
    cycles(8);
    io_in[3] = 1'b1;
    cycles(3);
    wr(OFS_IRQ_STAT, 32'h8, "w1c vs set");
    rd(OFS_IRQ_STAT, 32'h8, "STAT set wins");
    check("irq set wins", {31'b0, irq}, 32'd1);
    wr(OFS_IRQ_STAT, 32'h8, "w1c STAT2");
    rd(OFS_IRQ_STAT, 32'h0, "STAT clear2");

    // level interrupt, active low, not enabled
    wr(OFS_IRQ_MODE, 32'h20, "wr MODE");
    wr(OFS_IRQ_POL, 32'h20, "wr POL");
    cycles(2);
    rd(OFS_IRQ_STAT, 32'h20, "STAT level");
    check("irq masked", {31'b0, irq}, 32'd0);
    wr(OFS_IRQ_STAT, 32'h20, "w1c level");
    rd(OFS_IRQ_STAT, 32'h20, "STAT level reassert");
    io_in[5] = 1'b1;
    cycles(8);
    wr(OFS_IRQ_STAT, 32'h20, "w1c level2");
    rd(OFS_IRQ_STAT, 32'h0, "STAT level gone");

    // byte selects
    bus(1'b1, BASE + {24'h0, OFS_OUT}, 4'b0010, 32'hFFFF_FFFF, "wr OUT sel");
    check("io_out sel", io_out, 32'h0000_FF81);
    rd(OFS_OUT, 32'h0000_FF81, "rd OUT sel");

    // decode miss: never acked
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("miss no ack", {31'b0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0; adr = '0; sel = '0;
    cycles(1);

    // unmapped offset in window
    wr(8'h3C, 32'hFFFF_FFFF, "wr 0x3C");
    rd(8'h3C, 32'h0, "rd 0x3C");
    rd(OFS_OUT, 32'h0000_FF81, "OUT untouched");

    // reset during the ack cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
    @(posedge clk); #1;
    check("pre-rst ack", {31'b0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst ack", {31'b0, ack}, 32'd0);
    check("mid-rst io_oeb", io_oeb, 32'hFFFF_FFFF);
    check("mid-rst io_out", io_out, 32'h0);
    cyc = 1'b0; stb = 1'b0; adr = '0; sel = '0;
    cycles(2);
    rst_n = 1'b1;
    io_in = '0;
    cycles(2);
    rd(OFS_OUT, 32'h0, "post-rst OUT");
    rd(OFS_IRQ_POL, 32'h0, "post-rst POL");
    check("scoreboard drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_gpio_bank.md
Name: wb_gpio_bank

Overview:
- Parametrised successor to the single-instance Wishbone PIO: a Wishbone-slave GPIO bank of NUM_IO pins.
- Per-pin direction and atomic set/clear/toggle of outputs; synchronised and glitch-filtered inputs; per-pin edge or level interrupts aggregated onto one IRQ line.
- Instantiated in user_project_wrapper between the Caravel Wishbone bus and the io_in/io_out/io_oeb pads.

Parameters:
- NUM_IO, 32, pin count, 1..32.
- BASE_ADDR, 32'h3000_0000, Wishbone window base; decode on wbs_adr_i[31:8].
- SYNC_STAGES, 2, input synchroniser depth, at least 2.
- FILT_W, 8, glitch-filter counter width.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- io_in  in  NUM_IO  pad inputs (asynchronous).
- io_out  out  NUM_IO  pad outputs.
- io_oeb  out  NUM_IO  pad output enable, active-low.
- irq_o  out  1  aggregated interrupt.

Behaviour:
- Reset values: all registers 0; io_out=0; io_oeb all ones; wbs_ack_o=0; wbs_dat_o=0; irq_o=0; synchroniser, filter counters and filtered inputs 0.
- Bus decode: hit when cyc&stb and wbs_adr_i[31:8]==BASE_ADDR[31:8].
- Bus ack: registered, asserted exactly one cycle after hit, held one cycle, and deasserted for at least one cycle before the next ack. Misses are never acked.
- Bus data: wbs_dat_o is valid in the ack cycle and 0 otherwise. Unmapped offsets in the window read 0, ignore writes, and still ack. Bits at index NUM_IO and above read 0.
- Writes: take effect on the ack edge. wbs_sel_i masks bytes for RW and W1x registers.
- Register map (byte offset):
  - 0x00 OUT RW.
  - 0x04 OUT_SET W1S, reads 0.
  - 0x08 OUT_CLR W1C, reads 0.
  - 0x0C OUT_TGL W1T, reads 0.
  - 0x10 OE RW; io_oeb=~OE.
  - 0x14 IN RO, filtered inputs.
  - 0x18 IRQ_EN RW.
  - 0x1C IRQ_MODE RW; 0=edge, 1=level.
  - 0x20 IRQ_POL RW; edge: 0=rising, 1=falling; level: 0=high, 1=low.
  - 0x24 IRQ_STAT; read pending, write W1C.
  - 0x28 FILT RW, bits [FILT_W-1:0].
- Outputs: io_out=OUT, registered, updating the cycle after ack.
- Input path, per pin: SYNC_STAGES flops produce s, then the filter:
  - If s==f, cnt<=0.
  - Else if cnt==FILT, f<=s and cnt<=0.
  - Else cnt<=cnt+1.
  - FILT=0 gives f=s one cycle after sync.
  - io_in-to-IN latency is SYNC_STAGES+FILT+1 cycles for a stable input. Pulses of FILT cycles or fewer are rejected.
  - Changing FILT mid-count applies immediately; the comparison is ==, so a counter already above the new FILT runs to wrap-around at 2^FILT_W before it can match again.
- Interrupt detection uses registered f_prev. The condition per mode:
  - Edge mode: rising is f&~f_prev; falling is ~f&f_prev.
  - Level mode: f==~POL, evaluated every cycle.
- Interrupt status and output:
  - The condition sets IRQ_STAT regardless of IRQ_EN.
  - A W1C in the same cycle as a set leaves the bit set (set wins). In level mode a bit cleared while its level persists re-asserts the next cycle.
  - irq_o = registered |(IRQ_STAT & IRQ_EN), so it follows IRQ_STAT by one cycle.
  - Changing IRQ_MODE or IRQ_POL does not clear IRQ_STAT.
- Reset asserted mid-transaction: ack drops immediately, all state returns to reset values, and the bus sees no ack for that cycle.

Decomposition:
- Package wb_gpio_pkg holds:
  - register offset localparams (OFS_OUT … OFS_FILT);
  - IRQ_MODE_EDGE/IRQ_MODE_LEVEL constants;
  - WB_DECODE_MSB/LSB.
- Sub-module gpio_in_filter, one instance per pin via generate: synchroniser, filter counter, f and f_prev outputs. The top level holds the bus FSM (IDLE, ACK), the register file and the IRQ logic.

Test Plan:
- Reset → io_oeb=0xFFFF_FFFF, io_out=0, irq_o=0; reading 0x00, 0x10 and 0x24 returns 0. Each access acks exactly one cycle after stb.
- OE←0x0000_00FF, then OUT←0x0000_00F0, then OUT_SET←0x0F, OUT_CLR←0x81, OUT_TGL←0xFF → io_out reads 0xF0, 0xFF, 0x7E, 0x81 in turn. io_oeb=0xFFFF_FF00.
- FILT←4; io_in[0] high for 3 cycles → IN[0] stays 0. io_in[0] held high → IN[0]=1 exactly SYNC_STAGES+5 cycles after the edge.
- IRQ_EN[3]=1, edge rising; io_in[3] 0→1 → IRQ_STAT=0x8, then irq_o=1. W1C 0x8 → irq_o=0. A second rising edge landing in the same cycle as a W1C → bit stays 1.
- IRQ_MODE[5]=1, POL[5]=1, io_in[5] low → IRQ_STAT[5] set. W1C while still low → re-reads 1. After io_in[5] goes high, W1C → stays 0.
- Write OUT with sel=4'b0010, dat=0xFFFF_FFFF → only bits 15:8 change. Access to adr BASE+0x100 → no ack. Access to BASE+0x3C → ack, reads 0.
